ps2_keyboard: RTL and testbench
===============================

PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 TIMEOUT_CYCLES, 2000, clk2MHz cycles without a PS/2 falling edge before an in-progress frame is abandoned.
REQ-002 LINKS, 8'h00, startup-link bits read at row 0, columns 2-9; bit n maps to column n+2.
REQ-003 clk2MHz  in  1  sole clock.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 PS2_CLK  in  1  raw PS/2 clock, asynchronous.
REQ-006 PS2_DATA  in  1  raw PS/2 data, asynchronous.
REQ-007 nKBEN  in  1  slow-bus latch bit 3; 0 = direct read, 1 = autoscan.
REQ-008 COLUMN  in  4  PA[3:0] column select.
REQ-009 ROW  in  3  PA[6:4] row select.
REQ-010 KEY_PRESSED  out  1  PA7 key-down for the selected row/column.
REQ-011 KB_IRQ  out  1  CA2: any key in rows 1-7 down in the current column.
REQ-012 BREAK_KEY  out  1  BREAK key held.
REQ-013 RX_ERR  out  1  one-cycle pulse on a bad frame.

Function
REQ-014 PS2_CLK and PS2_DATA each SHALL pass through a 2-flop synchroniser; bits are sampled on the synchronised PS2_CLK falling edge.
REQ-015 Receiver FSM states: IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: a sampled 0 moves to DATA; a sampled 1 stays in IDLE with no error.
REQ-017 DATA: 8 bits, LSB first, then PARITY.
REQ-018 PARITY: the bit SHALL make the total odd.
REQ-019 STOP: the bit SHALL be 1.
REQ-020 Parity or stop failure SHALL discard the byte, pulse RX_ERR for one cycle and return to IDLE.
REQ-021 In any non-IDLE state, TIMEOUT_CYCLES cycles without a falling edge SHALL return the FSM to IDLE, discard the frame and leave RX_ERR low.
REQ-022 A good frame SHALL assert an internal byte-valid strobe for one cycle, on the cycle after the stop-bit edge.
REQ-023 Decoder byte handling:
  - F0 sets the break flag.
  - E0 sets the extended flag.
  - E1 discards the next 7 bytes.
  - Any other byte is looked up on {extended, code} in the team BBC key map; on a hit the matrix bit is set on make, cleared on break; both flags then clear.
  - An unmapped byte clears both flags and changes nothing else.
REQ-024 Matrix: 8 rows x 10 columns; BBC key number = {row, column}.
  - Required map entries: 1C->0x41 (A), 29->0x62 (SPACE), 5A->0x49 (RETURN), 76->0x70 (ESCAPE), 12/59->0x00 (SHIFT), 14 and E0 14->0x01 (CTRL).
REQ-025 PS/2 code 07 (F12) SHALL drive BREAK_KEY (1 on make, 0 on break) and never the matrix.
REQ-026 A matrix update SHALL become visible on the cycle after byte-valid.
REQ-027 KEY_PRESSED SHALL be combinational in COLUMN/ROW.
  - Columns 10-15 read 0.
  - Row 0, columns 2-9 read LINKS OR the matrix bit.
REQ-028 Scan counter, 4 bits:
  - nKBEN=0: loads COLUMN every cycle.
  - nKBEN=1: increments every second clk2MHz cycle (1 MHz), wrapping 15->0.
REQ-029 KB_IRQ SHALL be registered: the OR of rows 1-7 in the column given by the scan counter, one cycle of latency; 0 for columns 10-15.
REQ-030 Row-0 keys (SHIFT, CTRL, links) SHALL never assert KB_IRQ.
REQ-031 Make and break of the same key on consecutive strobes SHALL produce the correct final state; a make of an already-pressed key is idempotent.

Reset
REQ-032 While RESET=1 at a clock edge, the following SHALL clear or return to their idle values:
  - receiver FSM to IDLE; shift register, timeout count and E1 skip count to 0;
  - both decoder flags and the full matrix cleared;
  - scan counter 0, prescale phase 0;
  - KB_IRQ, BREAK_KEY, RX_ERR all 0.
REQ-033 Reset mid-frame SHALL discard the partial frame; the next complete frame SHALL decode normally.

Verification
REQ-034 Frame 1C, nKBEN=0, COLUMN=1, ROW=4 -> KEY_PRESSED=1 the cycle after the strobe; then F0,1C -> KEY_PRESSED=0.
REQ-035 Frame 1C with even parity -> RX_ERR one-cycle pulse; matrix all zero; next good 29 -> 0x62 set.
REQ-036 29 held, nKBEN=1 -> KB_IRQ=1 only while the counter=2 (plus one cycle latency), pulsing every 32 cycles; with only 12 held -> KB_IRQ stays 0.
REQ-037 5 bits of a frame, then a 2000-cycle stall -> FSM IDLE, RX_ERR=0; following frame 76 -> 0x70 set.
REQ-038 07 -> BREAK_KEY=1 and matrix unchanged; E0,14 -> 0x01 set; F0,07 -> BREAK_KEY=0.
REQ-039 RESET asserted after the parity bit of 5A -> matrix clear, no RX_ERR; a fresh 5A sets 0x49.

Source files
------------

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 keyboard receiver that maintains a BBC-style 8x10 key matrix.
//
// A PS/2 frame is 11 bits: start(0), 8 data bits LSB first, odd parity, stop(1).
// Bits are taken on falling edges of the synchronised PS/2 clock. Each good byte
// goes to a decoder that tracks the F0 (break) and E0 (extended) prefixes and the
// E1 (pause) sequence, and sets or clears matrix bits through a fixed key map.
// Matrix bit index = row*10 + column, and BBC key number = {row, column}.
//
// Ports:
//   clk2MHz     in   sole clock
//   RESET       in   synchronous active-high reset
//   PS2_CLK     in   raw PS/2 clock (asynchronous)
//   PS2_DATA    in   raw PS/2 data (asynchronous)
//   nKBEN       in   0 = scan counter follows COLUMN, 1 = free-running autoscan
//   COLUMN[3:0] in   column select
//   ROW[2:0]    in   row select
//   KEY_PRESSED out  combinational key-down for ROW/COLUMN
//   KB_IRQ      out  registered OR of rows 1-7 in the scanned column
//   BREAK_KEY   out  BREAK key (PS/2 F12) held
//   RX_ERR      out  one-cycle pulse on a parity or stop-bit failure
//   RX_STATE    out  receiver FSM state for observation (0 IDLE, 1 DATA, 2 PARITY, 3 STOP)
//
// Handshake: there is no back-pressure. The internal byte strobe is valid for
// exactly one cycle, and the decoder must consume the byte in that cycle.
module ps2_keyboard #(
    parameter int         TIMEOUT_CYCLES = 2000,
    parameter logic [7:0] LINKS          = 8'h00
) (
    input  logic       clk2MHz,
    input  logic       RESET,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    input  logic       nKBEN,
    input  logic [3:0] COLUMN,
    input  logic [2:0] ROW,
    output logic       KEY_PRESSED,
    output logic       KB_IRQ,
    output logic       BREAK_KEY,
    output logic       RX_ERR,
    output logic [1:0] RX_STATE
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // Encoding follows the order IDLE, DATA, PARITY, STOP.
    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    logic            clk_s1_q, clk_s2_q, clk_prev_q, data_s1_q, data_s2_q;
    logic            clk_s1_d, clk_s2_d, clk_prev_d, data_s1_d, data_s2_d;
    rx_state_t       state_q, state_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic            parity_q, parity_d;
    logic [TW-1:0]   timeout_q, timeout_d;
    logic            byte_valid_q, byte_valid_d;
    logic            rx_err_q, rx_err_d;
    logic            brk_q, brk_d, ext_q, ext_d;
    logic [2:0]      skip_q, skip_d;
    logic [79:0]     matrix_q, matrix_d;
    logic            break_key_q, break_key_d;
    logic [3:0]      scan_q, scan_d;
    logic            pre_q, pre_d;
    logic            kb_irq_q, kb_irq_d;
    logic            ps2_fall;
    logic            map_hit;
    logic [6:0]      map_key, map_idx, sel_idx;
    logic [3:0]      link_col;

    // Two-flop synchronisers, plus one more stage on the clock for edge detection.
    always_comb begin
        clk_s1_d   = PS2_CLK;
        clk_s2_d   = clk_s1_q;
        clk_prev_d = clk_s2_q;
        data_s1_d  = PS2_DATA;
        data_s2_d  = data_s1_q;
    end

    assign ps2_fall = clk_prev_q & ~clk_s2_q;

    // Receiver next state. The frame is checked as a whole on the stop-bit edge.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        parity_d     = parity_q;
        timeout_d    = timeout_q;
        byte_valid_d = 1'b0;
        rx_err_d     = 1'b0;
        if (state_q != RX_IDLE) begin
            if (ps2_fall) begin
                timeout_d = '0;
            end else if (timeout_q == TW'(TIMEOUT_CYCLES - 1)) begin
                // Stalled frame: abandon it without reporting an error.
                state_d   = RX_IDLE;
                timeout_d = '0;
            end else begin
                timeout_d = timeout_q + 1'b1;
            end
        end
        if (ps2_fall) begin
            case (state_q)
                RX_IDLE: begin
                    if (!data_s2_q) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = '0;
                    end
                end
                RX_DATA: begin
                    shift_d   = {data_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
                end
                RX_PARITY: begin
                    parity_d = data_s2_q;
                    state_d  = RX_STOP;
                end
                RX_STOP: begin
                    state_d = RX_IDLE;
                    if (data_s2_q && (^{shift_q, parity_q})) byte_valid_d = 1'b1;
                    else                                     rx_err_d     = 1'b1;
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    // Key map: {extended, code} -> BBC key number {row, column}.
    always_comb begin
        map_hit = 1'b1;
        map_key = 7'h00;
        case ({ext_q, shift_q})
            9'h01C:        map_key = 7'h41;  // A
            9'h029:        map_key = 7'h62;  // SPACE
            9'h05A:        map_key = 7'h49;  // RETURN
            9'h076:        map_key = 7'h70;  // ESCAPE
            9'h012, 9'h059: map_key = 7'h00; // SHIFT (left/right)
            9'h014, 9'h114: map_key = 7'h01; // CTRL (left/right)
            default:       map_hit = 1'b0;
        endcase
        map_idx = 7'(map_key[6:4]) * 7'd10 + 7'(map_key[3:0]);
    end

    // Decoder: prefixes set flags; a final byte updates state and clears both flags.
    always_comb begin
        brk_d       = brk_q;
        ext_d       = ext_q;
        skip_d      = skip_q;
        matrix_d    = matrix_q;
        break_key_d = break_key_q;
        if (byte_valid_q) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 1'b1;
            end else begin
                case (shift_q)
                    8'hF0: brk_d  = 1'b1;
                    8'hE0: ext_d  = 1'b1;
                    8'hE1: skip_d = 3'd7;
                    default: begin
                        brk_d = 1'b0;
                        ext_d = 1'b0;
                        // F12 is the BREAK key and has no matrix position.
                        if ({ext_q, shift_q} == 9'h007) break_key_d = ~brk_q;
                        else if (map_hit)               matrix_d[map_idx] = ~brk_q;
                    end
                endcase
            end
        end
    end

    // Scan counter and registered column interrupt. Row 0 never contributes.
    always_comb begin
        scan_d   = scan_q;
        pre_d    = 1'b0;
        kb_irq_d = 1'b0;
        if (!nKBEN) begin
            scan_d = COLUMN;
        end else begin
            pre_d = ~pre_q;
            if (pre_q) scan_d = scan_q + 1'b1;
        end
        if (scan_q < 4'd10) begin
            for (int r = 1; r < 8; r++) begin
                kb_irq_d = kb_irq_d | matrix_q[7'(r * 10) + 7'(scan_q)];
            end
        end
    end

    always_ff @(posedge clk2MHz) begin
        if (RESET) begin
            clk_s1_q     <= 1'b1;
            clk_s2_q     <= 1'b1;
            clk_prev_q   <= 1'b1;
            data_s1_q    <= 1'b1;
            data_s2_q    <= 1'b1;
            state_q      <= RX_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            parity_q     <= 1'b0;
            timeout_q    <= '0;
            byte_valid_q <= 1'b0;
            rx_err_q     <= 1'b0;
            brk_q        <= 1'b0;
            ext_q        <= 1'b0;
            skip_q       <= '0;
            matrix_q     <= '0;
            break_key_q  <= 1'b0;
            scan_q       <= '0;
            pre_q        <= 1'b0;
            kb_irq_q     <= 1'b0;
        end else begin
            clk_s1_q     <= clk_s1_d;
            clk_s2_q     <= clk_s2_d;
            clk_prev_q   <= clk_prev_d;
            data_s1_q    <= data_s1_d;
            data_s2_q    <= data_s2_d;
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            parity_q     <= parity_d;
            timeout_q    <= timeout_d;
            byte_valid_q <= byte_valid_d;
            rx_err_q     <= rx_err_d;
            brk_q        <= brk_d;
            ext_q        <= ext_d;
            skip_q       <= skip_d;
            matrix_q     <= matrix_d;
            break_key_q  <= break_key_d;
            scan_q       <= scan_d;
            pre_q        <= pre_d;
            kb_irq_q     <= kb_irq_d;
        end
    end

    // Direct read path: columns 10-15 are empty; row 0 columns 2-9 include the links.
    always_comb begin
        sel_idx     = 7'(ROW) * 7'd10 + 7'(COLUMN);
        link_col    = COLUMN - 4'd2;
        KEY_PRESSED = 1'b0;
        if (COLUMN < 4'd10) begin
            KEY_PRESSED = matrix_q[sel_idx];
            if (ROW == 3'd0 && COLUMN >= 4'd2) KEY_PRESSED = KEY_PRESSED | LINKS[link_col[2:0]];
        end
    end

    assign KB_IRQ    = kb_irq_q;
    assign BREAK_KEY = break_key_q;
    assign RX_ERR    = rx_err_q;
    assign RX_STATE  = state_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard: drives PS/2 frames into ps2_keyboard and checks the outputs
// against a byte-level model of the key matrix, prefix flags and BREAK key.
module tb_ps2_keyboard;

    localparam logic [7:0] LINKS = 8'h00;

    logic       clk2MHz, RESET, PS2_CLK, PS2_DATA, nKBEN;
    logic [3:0] COLUMN;
    logic [2:0] ROW;
    logic       KEY_PRESSED, KB_IRQ, BREAK_KEY, RX_ERR;
    logic [1:0] RX_STATE;

    int checks = 0;
    int errors = 0;

    // Model state: key matrix, BREAK key, prefix flags, skip count, pending good bytes.
    logic       model_m [0:7][0:9];
    logic       model_bk;
    logic       m_brk, m_ext;
    int         m_skip;
    logic [7:0] exp_q[$];

    logic settled = 1'b0;
    logic wiggle  = 1'b0;

    ps2_keyboard #(.TIMEOUT_CYCLES(2000), .LINKS(LINKS)) dut (
        .clk2MHz(clk2MHz), .RESET(RESET), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
        .nKBEN(nKBEN), .COLUMN(COLUMN), .ROW(ROW), .KEY_PRESSED(KEY_PRESSED),
        .KB_IRQ(KB_IRQ), .BREAK_KEY(BREAK_KEY), .RX_ERR(RX_ERR), .RX_STATE(RX_STATE)
    );

    // Clock and reset block.
    initial begin
        clk2MHz = 1'b0;
        forever #5 clk2MHz = ~clk2MHz;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 20) $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    function automatic int map_lookup(input logic ext, input logic [7:0] code);
        case ({ext, code})
            9'h01C: return 'h41;
            9'h029: return 'h62;
            9'h05A: return 'h49;
            9'h076: return 'h70;
            9'h012, 9'h059: return 'h00;
            9'h014, 9'h114: return 'h01;
            default: return -1;
        endcase
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 10; c++) model_m[r][c] = 1'b0;
        model_bk = 1'b0;
        m_brk    = 1'b0;
        m_ext    = 1'b0;
        m_skip   = 0;
        exp_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        int k;
        if (m_skip > 0) begin
            m_skip--;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hE1) begin
            m_skip = 7;
        end else begin
            k = map_lookup(m_ext, b);
            if (!m_ext && b == 8'h07) model_bk = !m_brk;
            else if (k >= 0) model_m[k / 16][k % 16] = !m_brk;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    function automatic logic model_kp(input int row, input int col);
        logic [7:0] lk;
        lk = LINKS;
        if (col >= 10) return 1'b0;
        if (row == 0 && col >= 2) return model_m[row][col] | lk[col - 2];
        return model_m[row][col];
    endfunction

    function automatic logic model_irq(input int col);
        logic v;
        v = 1'b0;
        if (col < 10)
            for (int r = 1; r < 8; r++) v = v | model_m[r][col];
        return v;
    endfunction

    function automatic int model_count();
        int n;
        n = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 10; c++) n += model_kp(r, c);
        return n;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk2MHz);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        tick(1);
        PS2_DATA = b;
        tick(4);
        PS2_CLK = 1'b0;
        tick(8);
        PS2_CLK = 1'b1;
        tick(3);
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic bad);
        logic p;
        p = bad ? (^b) : ~(^b);
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic send_partial(input logic [7:0] b, input int nbits);
        logic [10:0] fr;
        fr = frame_bits(b, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(fr[i]);
    endtask

    // Full frame. Around the stop-bit edge the bench watches RX_ERR and KEY_PRESSED
    // for six cycles, then folds any good byte into the model.
    task automatic send_frame(input logic [7:0] b, input logic bad, output int kp_first);
        logic [10:0] fr;
        int rx_cnt, rx_pos;
        fr = frame_bits(b, bad);
        for (int i = 0; i < 10; i++) send_bit(fr[i]);
        tick(1);
        PS2_DATA = fr[10];
        tick(4);
        settled  = 1'b0;
        PS2_CLK  = 1'b0;
        kp_first = 0;
        rx_cnt   = 0;
        rx_pos   = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk2MHz);
            if (KEY_PRESSED === 1'b1 && kp_first == 0) kp_first = i;
            if (RX_ERR === 1'b1) begin
                rx_cnt++;
                rx_pos = i;
            end
        end
        chk("rx_err_pulse_count", rx_cnt, bad ? 1 : 0);
        if (bad) chk("rx_err_pulse_pos", rx_pos, 4);
        else     exp_q.push_back(b);
        tick(2);
        PS2_CLK = 1'b1;
        while (exp_q.size() > 0) model_byte(exp_q.pop_front());
        settled = 1'b1;
        tick(4);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int kp;
        send_frame(b, 1'b0, kp);
    endtask

    task automatic scan_matrix(output int cnt);
        cnt = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 10; c++) begin
                @(posedge clk2MHz);
                #1;
                ROW    = 3'(r);
                COLUMN = 4'(c);
                @(negedge clk2MHz);
                cnt += int'(KEY_PRESSED);
            end
    endtask

    task automatic sel_check(input string name, input int r, input int c, input logic exp);
        tick(1);
        ROW    = 3'(r);
        COLUMN = 4'(c);
        @(negedge clk2MHz);
        chk(name, KEY_PRESSED, exp);
    endtask

    task automatic irq_window(output int highs, output int gap);
        int first, second;
        logic prev;
        highs  = 0;
        first  = -1;
        second = -1;
        prev   = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk2MHz);
            if (KB_IRQ === 1'b1) highs++;
            if (KB_IRQ === 1'b1 && !prev) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
            prev = KB_IRQ;
        end
        gap = (first >= 0 && second >= 0) ? second - first : -1;
    endtask

    // Random ROW/COLUMN changes while enabled.
    initial begin
        forever begin
            @(posedge clk2MHz);
            #1;
            if (wiggle) begin
                ROW    = 3'($urandom_range(0, 7));
                COLUMN = 4'($urandom_range(0, 15));
            end
        end
    end

    // Compare process: every settled cycle, outputs must match the model.
    initial begin
        int settle_cnt, col_h1, col_h2;
        logic kben_h1, kben_h2;
        settle_cnt = 0;
        col_h1 = 0;
        col_h2 = 0;
        kben_h1 = 1'b1;
        kben_h2 = 1'b1;
        forever begin
            @(negedge clk2MHz);
            settle_cnt = settled ? settle_cnt + 1 : 0;
            if (settle_cnt > 0 && RESET === 1'b0) begin
                chk("key_pressed", KEY_PRESSED, model_kp(int'(ROW), int'(COLUMN)));
                chk("break_key", BREAK_KEY, model_bk);
                chk("rx_err_quiet", RX_ERR, 1'b0);
            end
            // KB_IRQ reflects the column presented two samples earlier.
            if (settle_cnt >= 3 && RESET === 1'b0 && !kben_h1 && !kben_h2)
                chk("kb_irq", KB_IRQ, model_irq(col_h2));
            col_h2  = col_h1;
            col_h1  = int'(COLUMN);
            kben_h2 = kben_h1;
            kben_h1 = nKBEN;
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int kp, cnt, highs, gap, sel, brk;
        logic [7:0] codes [0:11];
        logic       exts  [0:11];
        codes = '{8'h1C, 8'h29, 8'h5A, 8'h76, 8'h12, 8'h59, 8'h14, 8'h07, 8'h33, 8'h14, 8'h1C, 8'h07};
        exts  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        PS2_CLK  = 1'b1;
        PS2_DATA = 1'b1;
        RESET    = 1'b1;
        nKBEN    = 1'b0;
        ROW      = 3'd0;
        COLUMN   = 4'd0;
        model_clear();
        tick(4);
        @(negedge clk2MHz);
        chk("reset_kb_irq", KB_IRQ, 1'b0);
        chk("reset_break_key", BREAK_KEY, 1'b0);
        chk("reset_rx_err", RX_ERR, 1'b0);
        chk("reset_rx_state", RX_STATE, 2'd0);
        tick(1);
        RESET = 1'b0;
        tick(3);
        settled = 1'b1;

        // A: make then break, with make latency pinned.
        tick(1);
        ROW    = 3'd4;
        COLUMN = 4'd1;
        send_frame(8'h1C, 1'b0, kp);
        chk("a_make_latency", kp, 5);
        sel_check("a_after_make", 4, 1, 1'b1);
        send_byte(8'hF0);
        send_byte(8'h1C);
        sel_check("a_after_break", 4, 1, 1'b0);

        // Bad parity frame is dropped, next good frame decodes.
        send_frame(8'h1C, 1'b1, kp);
        scan_matrix(cnt);
        chk("bad_frame_matrix_empty", cnt, 0);
        send_byte(8'h29);
        sel_check("space_set", 6, 2, 1'b1);

        // Autoscan: SPACE in column 2 pulses KB_IRQ for two cycles every 32.
        tick(1);
        nKBEN = 1'b1;
        tick(40);
        irq_window(highs, gap);
        chk("scan_irq_highs", highs, 4);
        chk("scan_irq_period", gap, 32);
        send_byte(8'hF0);
        send_byte(8'h29);
        send_byte(8'h12);
        tick(40);
        irq_window(highs, gap);
        chk("scan_row0_no_irq", highs, 0);
        sel_check("shift_set", 0, 0, 1'b1);
        tick(1);
        nKBEN = 1'b0;
        send_byte(8'hF0);
        send_byte(8'h12);

        // Stalled frame times out silently.
        send_partial(8'hA5, 5);
        @(negedge clk2MHz);
        chk("stall_in_data", RX_STATE, 2'd1);
        tick(1960);
        @(negedge clk2MHz);
        chk("stall_before_timeout", RX_STATE, 2'd1);
        tick(60);
        @(negedge clk2MHz);
        chk("stall_timed_out", RX_STATE, 2'd0);
        send_byte(8'h76);
        sel_check("escape_set", 7, 0, 1'b1);

        // F12 drives BREAK_KEY only; extended CTRL maps to 0x01.
        scan_matrix(cnt);
        send_byte(8'h07);
        @(negedge clk2MHz);
        chk("break_key_make", BREAK_KEY, 1'b1);
        scan_matrix(highs);
        chk("break_key_matrix_unchanged", highs, cnt);
        send_byte(8'hE0);
        send_byte(8'h14);
        sel_check("ext_ctrl_set", 0, 1, 1'b1);
        send_byte(8'hF0);
        send_byte(8'h07);
        @(negedge clk2MHz);
        chk("break_key_release", BREAK_KEY, 1'b0);

        // E1 swallows the next seven bytes.
        send_byte(8'hE1);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h29);
        send_byte(8'h5A);
        send_byte(8'hE0);
        send_byte(8'h12);
        send_byte(8'h59);
        sel_check("e1_skipped_a", 4, 1, 1'b0);
        sel_check("e1_skipped_shift", 0, 0, 1'b0);
        send_byte(8'h5A);
        sel_check("e1_then_return", 4, 9, 1'b1);

        // Reset after the parity bit of 5A.
        send_partial(8'h5A, 10);
        settled = 1'b0;
        RESET   = 1'b1;
        tick(2);
        @(negedge clk2MHz);
        chk("midreset_rx_err", RX_ERR, 1'b0);
        chk("midreset_kb_irq", KB_IRQ, 1'b0);
        tick(1);
        RESET = 1'b0;
        model_clear();
        tick(3);
        settled = 1'b1;
        send_bit(1'b1);
        tick(10);
        scan_matrix(cnt);
        chk("midreset_matrix_clear", cnt, 0);
        send_byte(8'h5A);
        sel_check("midreset_fresh_return", 4, 9, 1'b1);

        // Random key traffic with random ROW/COLUMN reads.
        wiggle = 1'b1;
        for (int e = 0; e < 50; e++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                send_byte(8'hE1);
                for (int j = 0; j < 7; j++) send_byte(8'($urandom_range(0, 255)));
            end else if (sel == 1) begin
                send_frame(8'($urandom_range(0, 255)), 1'b1, kp);
            end else begin
                sel = $urandom_range(0, 11);
                brk = $urandom_range(0, 1);
                if (exts[sel]) send_byte(8'hE0);
                if (brk == 1) send_byte(8'hF0);
                send_byte(codes[sel]);
            end
        end
        wiggle = 1'b0;
        scan_matrix(cnt);
        chk("random_final_count", cnt, model_count());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
